alu_iter: RTL and testbench



---
 rtl/alu_iter.sv | 176 +++++++++++++++++
 tb/tb_alu_iter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_iter.sv
// alu_iter: iterative 16-bit execute unit.
// Add and logic ops complete in one cycle. Shifts and rotates move one bit per cycle.
// Handshakes, both sides: a transfer happens on a rising edge where valid and ready are both high.
// in_ready is high only in IDLE. out_valid is high only in DONE, so the two are never high together.
// Inputs are sampled only on the accepting edge.
// Out, Ofl and Zero hold steady while out_valid waits for out_ready.
module alu_iter #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [2:0]   aluOp,
  input  logic         invA,
  input  logic         invB,
  input  logic         Cin,
  input  logic         sign,
  input  logic         rorSel,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Out,
  output logic         Ofl,
  output logic         Zero
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Shift flavours latched at accept, because the inputs may change after the accepting edge
  localparam logic [1:0] K_ROL = 2'd0;
  localparam logic [1:0] K_ROR = 2'd1;
  localparam logic [1:0] K_SLL = 2'd2;
  localparam logic [1:0] K_SRL = 2'd3;

  state_t       state, state_nxt;
  logic [N-1:0] acc;
  logic [3:0]   cnt;
  logic [1:0]   kind;

  logic [N-1:0] a_c, b_c;
  logic [3:0]   amt;
  logic         is_shift;
  logic [1:0]   kind_in;
  logic [N:0]   sum;
  logic [N-1:0] alu_res;
  logic         alu_ofl;
  logic         accept;
  logic [N-1:0] first_step, next_step;

  // One-bit shift/rotate step shared by the accept edge and the SHIFT state
  function automatic logic [N-1:0] step(input logic [N-1:0] v, input logic [1:0] k);
    case (k)
      K_ROL:   step = {v[N-2:0], v[N-1]};
      K_ROR:   step = {v[0], v[N-1:1]};
      K_SLL:   step = {v[N-2:0], 1'b0};
      default: step = {1'b0, v[N-1:1]};
    endcase
  endfunction

  // Operand conditioning, op decode and the single-cycle arithmetic/logic result
  always_comb begin
    a_c      = invA ? ~A : A;
    b_c      = invB ? ~B : B;
    amt      = B[3:0];
    is_shift = ~aluOp[2];
    case (aluOp[1:0])
      2'b00:   kind_in = rorSel ? K_ROR : K_ROL;
      2'b01:   kind_in = K_SLL;
      2'b11:   kind_in = K_SRL;
      default: kind_in = K_ROL;  // 010 is reserved and behaves as rotate left
    endcase
    sum     = {1'b0, a_c} + {1'b0, b_c} + {{N{1'b0}}, Cin};
    alu_res = sum[N-1:0];
    alu_ofl = 1'b0;
    case (aluOp[1:0])
      2'b00: begin
        alu_res = sum[N-1:0];
        alu_ofl = sign ? ((a_c[N-1] == b_c[N-1]) && (sum[N-1] != a_c[N-1])) : sum[N];
      end
      2'b01:   alu_res = a_c & b_c;
      2'b10:   alu_res = a_c | b_c;
      default: alu_res = a_c ^ b_c;
    endcase
    first_step = step(a_c, kind_in);
    next_step  = step(acc, kind);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. Flush beats both accept and out_ready.
  // The accepting edge already performs the first shift step, so a shift by n
  // reaches DONE n edges after accept and reports its result in the n-th cycle.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          if (!is_shift || amt <= 4'd1) state_nxt = S_DONE;
          else                          state_nxt = S_SHIFT;
        end
        S_SHIFT: if (cnt == 4'd1) state_nxt = S_DONE;
        S_DONE:  if (out_ready)   state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Handshake outputs decoded from the state
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
  end

  assign accept = in_valid & in_ready;

  // Datapath: accumulator, counter and the registered result triple
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      cnt  <= '0;
      kind <= K_ROL;
      Out  <= '0;
      Ofl  <= 1'b0;
      Zero <= 1'b1;
    end else if (flush) begin
      cnt <= '0;  // Out/Ofl/Zero keep their last values
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          if (!is_shift) begin
            Out  <= alu_res;
            Ofl  <= alu_ofl;
            Zero <= (alu_res == '0);
          end else if (amt == 4'd0) begin
            Out  <= a_c;
            Ofl  <= 1'b0;
            Zero <= (a_c == '0);
          end else if (amt == 4'd1) begin
            Out  <= first_step;
            Ofl  <= 1'b0;
            Zero <= (first_step == '0);
            cnt  <= '0;
          end else begin
            acc  <= first_step;
            cnt  <= amt - 4'd1;
            kind <= kind_in;
          end
        end
        S_SHIFT: begin
          acc <= next_step;
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            Out  <= next_step;
            Ofl  <= 1'b0;
            Zero <= (next_step == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: table-driven vectors checked through an expected-result queue,
// plus hand-written sequences for the stall, flush and reset-mid-shift cases.
module tb_alu_iter;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] A = '0, B = '0;
  logic [2:0]   aluOp = '0;
  logic         invA = 1'b0, invB = 1'b0, Cin = 1'b0, sign = 1'b0, rorSel = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] Out;
  logic         Ofl, Zero;

  int n_checks = 0;
  int n_fail   = 0;

  // expected {Ofl, Zero, Out}
  logic [N+1:0] exp_q[$];

  typedef struct {
    logic [N-1:0] a, b;
    logic [2:0]   op;
    logic         inva, invb, cin, sgn, ror;
    logic [N-1:0] exp_out;
    logic         exp_ofl;
    int           exp_lat;
  } vec_t;

  vec_t vecs[18];

  alu_iter #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .aluOp(aluOp),
    .invA(invA), .invB(invB), .Cin(Cin), .sign(sign), .rorSel(rorSel),
    .out_valid(out_valid), .out_ready(out_ready),
    .Out(Out), .Ofl(Ofl), .Zero(Zero)
  );

  // clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // the two handshake outputs must never be high together
  always @(negedge clk) begin
    if (rst_n) begin
      n_checks++;
      if (out_valid && in_ready) begin
        n_fail++;
        $display("FAIL handshake_exclusive: out_valid=%b in_ready=%b required not both 1", out_valid, in_ready);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] op,
                              input logic inva, input logic invb, input logic cin, input logic sgn,
                              input logic ror, input logic [N-1:0] eo, input logic eofl, input int el);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.inva = inva; v.invb = invb; v.cin = cin;
    v.sgn = sgn; v.ror = ror; v.exp_out = eo; v.exp_ofl = eofl; v.exp_lat = el;
    return v;
  endfunction

  task automatic scramble_inputs();
    A = N'($urandom_range(0, 65535)); B = N'($urandom_range(0, 65535));
    aluOp = 3'($urandom_range(0, 7));
    invA = 1'($urandom_range(0, 1)); invB = 1'($urandom_range(0, 1));
    Cin = 1'($urandom_range(0, 1)); sign = 1'($urandom_range(0, 1)); rorSel = 1'($urandom_range(0, 1));
  endtask

  // drive one op (called #1 after an edge), accept on the next edge, push expectation
  task automatic drive(input vec_t v);
    int guard = 0;
    while (!in_ready && guard < 50) begin tick(); guard++; end
    check("in_ready_before_drive", {31'd0, in_ready}, 32'd1);
    A = v.a; B = v.b; aluOp = v.op; invA = v.inva; invB = v.invb;
    Cin = v.cin; sign = v.sgn; rorSel = v.ror; in_valid = 1'b1;
    exp_q.push_back({v.exp_ofl, (v.exp_out == '0), v.exp_out});
    tick();
    in_valid = 1'b0;
    scramble_inputs();
  endtask

  // wait for out_valid, measure latency, compare against the queue head, then consume
  task automatic collect(input string name, input int exp_lat);
    int lat = 1;
    logic [N+1:0] exp;
    while (!out_valid && lat < 40) begin
      check({name, "_in_ready_busy"}, {31'd0, in_ready}, 32'd0);
      tick();
      lat++;
    end
    check({name, "_latency"}, lat, exp_lat);
    if (exp_q.size() == 0) begin
      check({name, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      exp = exp_q.pop_front();
      check({name, "_result"}, {14'd0, Ofl, Zero, Out}, {14'd0, exp});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_back_idle"}, {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    logic [N-1:0] held;

    vecs[0]  = mk(16'h7FFF, 16'h0001, 3'b100, 0, 0, 0, 1, 0, 16'h8000, 1'b1, 1);
    vecs[1]  = mk(16'h7FFF, 16'h0001, 3'b100, 0, 0, 0, 0, 0, 16'h8000, 1'b0, 1);
    vecs[2]  = mk(16'h0005, 16'h0005, 3'b100, 1, 0, 1, 1, 0, 16'h0000, 1'b0, 1);
    vecs[3]  = mk(16'hF0F0, 16'h0FF0, 3'b101, 0, 0, 0, 0, 0, 16'h00F0, 1'b0, 1);
    vecs[4]  = mk(16'hF000, 16'h000F, 3'b110, 0, 0, 0, 0, 0, 16'hF00F, 1'b0, 1);
    vecs[5]  = mk(16'hF0F0, 16'hFFFF, 3'b111, 0, 0, 0, 0, 0, 16'h0F0F, 1'b0, 1);
    vecs[6]  = mk(16'h0001, 16'h0004, 3'b000, 0, 0, 0, 0, 1, 16'h1000, 1'b0, 4);
    vecs[7]  = mk(16'h0001, 16'h000F, 3'b000, 0, 0, 0, 0, 0, 16'h8000, 1'b0, 15);
    vecs[8]  = mk(16'h0003, 16'h000F, 3'b001, 0, 0, 0, 0, 0, 16'h8000, 1'b0, 15);
    vecs[9]  = mk(16'h8000, 16'h0003, 3'b011, 0, 0, 0, 0, 0, 16'h1000, 1'b0, 3);
    vecs[10] = mk(16'h1234, 16'h0000, 3'b001, 0, 0, 0, 0, 0, 16'h1234, 1'b0, 1);
    vecs[11] = mk(16'h8001, 16'h0001, 3'b010, 0, 0, 0, 0, 1, 16'h0003, 1'b0, 1);
    vecs[12] = mk(16'hFFFF, 16'h0001, 3'b100, 0, 0, 0, 0, 0, 16'h0000, 1'b1, 1);
    vecs[13] = mk(16'hFFFF, 16'h00FF, 3'b101, 0, 1, 0, 0, 0, 16'hFF00, 1'b0, 1);
    vecs[14] = mk(16'hFFFE, 16'h0002, 3'b001, 1, 1, 0, 0, 0, 16'h0004, 1'b0, 2);
    vecs[15] = mk(16'h0001, 16'h0001, 3'b000, 0, 0, 0, 0, 1, 16'h8000, 1'b0, 1);
    vecs[16] = mk(16'h0001, 16'hFFF4, 3'b000, 0, 0, 0, 0, 1, 16'h1000, 1'b0, 4);
    vecs[17] = mk(16'h8000, 16'h0002, 3'b100, 0, 0, 0, 1, 0, 16'h8002, 1'b0, 1);

    // reset release with no stimulus
    #22;
    rst_n = 1'b1;
    tick();
    check("reset_state", {13'd0, Ofl, Zero, in_ready, out_valid, Out}, {13'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000});

    // table-driven vectors
    foreach (vecs[i]) begin
      drive(vecs[i]);
      collect($sformatf("vec%0d", i), vecs[i].exp_lat);
    end

    // consumer stall: result held while out_ready stays low
    drive(mk(16'hF0F0, 16'hFFFF, 3'b111, 0, 0, 0, 0, 0, 16'h0F0F, 1'b0, 1));
    for (int k = 0; k < 5; k++) begin
      check("stall_hold", {15'd0, out_valid, Out}, {15'd0, 1'b1, 16'h0F0F});
      tick();
    end
    collect("stall_release", 1);

    // flush at the 3rd cycle of an sll by 8
    held = Out;
    drive(mk(16'h00FF, 16'h0008, 3'b001, 0, 0, 0, 0, 0, 16'hFF00, 1'b0, 8));
    void'(exp_q.pop_back());  // flushed op never produces a result
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_idle", {30'd0, in_ready, out_valid}, 32'd2);
    check("flush_out_kept", {16'd0, Out}, {16'd0, held});
    for (int k = 0; k < 10; k++) begin
      check("flush_no_valid", {31'd0, out_valid}, 32'd0);
      tick();
    end

    // flush in IDLE beats accept
    A = 16'h0001; B = 16'h0001; aluOp = 3'b100; invA = 0; invB = 0; Cin = 0; sign = 0;
    in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    tick();
    check("flush_beats_accept", {30'd0, in_ready, out_valid}, 32'd2);

    // flush in DONE beats out_ready
    drive(mk(16'h0003, 16'h0004, 3'b110, 0, 0, 0, 0, 0, 16'h0007, 1'b0, 1));
    void'(exp_q.pop_back());
    check("done_before_flush", {15'd0, out_valid, Out}, {15'd0, 1'b1, 16'h0007});
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b0;
    check("flush_in_done", {14'd0, in_ready, out_valid, Out}, {14'd0, 1'b1, 1'b0, 16'h0007});

    // reset asserted mid-shift: outputs at reset values immediately
    drive(mk(16'h0001, 16'h0008, 3'b001, 0, 0, 0, 0, 0, 16'h0100, 1'b0, 8));
    void'(exp_q.pop_back());
    tick();
    rst_n = 1'b0;
    #1;
    check("reset_mid_shift", {13'd0, Ofl, Zero, in_ready, out_valid, Out}, {13'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000});
    tick();
    rst_n = 1'b1;
    tick();
    drive(mk(16'h4000, 16'h0002, 3'b011, 0, 0, 0, 0, 0, 16'h1000, 1'b0, 2));
    collect("after_reset", 2);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
